pulse_train_generator: RTL and testbench
========================================

# pulse_train_generator

Transmit-side counterpart to the edge and single-cycle-pulse detectors: converts a queue of pulse descriptors (high length, low length) into a registered single-bit waveform on `pulse`. It drives detector stimulus in benches and acts as a strobe/pattern source in datapaths. It has a valid/ready request port and supports zero-bubble back-to-back requests, so any bit pattern the detectors expect can be produced exactly.

## Interface
- `LEN_W`, default 8: width of the length fields; maximum phase length is 2^LEN_W − 1 cycles.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: descriptor present.
- `req_ready` out 1: generator accepts the descriptor this cycle.
- `req_high` in LEN_W: number of cycles `pulse` = 1.
- `req_low` in LEN_W: number of cycles `pulse` = 0 following the high phase.
- `pulse` out 1: generated waveform; driven directly from a flop.
- `busy` out 1: a descriptor is being played out (state ≠ IDLE).
- `done` out 1: one-cycle strobe on the final output cycle of a descriptor.

## Operation
- The FSM (`pulse_gen_state_t`) has three states: IDLE, HIGH, LOW. A loadable down-counter `cnt` of LEN_W bits tracks the current phase.
- Acceptance: a handshake occurs when `req_valid && req_ready`. `req_high`, `req_low` (and `req_repeat`, when configured) are captured on that edge.
- On accept with `req_high` > 0: go to HIGH, `cnt` = `req_high` − 1. With `req_high` = 0: go to LOW, `cnt` = `req_low` − 1. With both = 0: the descriptor is a no-op, state stays/returns IDLE, `done` pulses in the next cycle, and `pulse` stays 0.
- HIGH: `pulse` = 1. When `cnt` = 0: go to LOW if the captured low > 0. Otherwise the descriptor ends.
- LOW: `pulse` = 0. When `cnt` = 0 the descriptor ends.
- End of descriptor: if a new handshake occurs on the same edge, the FSM loads the new descriptor directly with no idle cycle. Otherwise it returns to IDLE.
- `req_ready` = (state = IDLE) or (`cnt` = 0 in the final phase of the current descriptor). It is combinational from state/`cnt` only and never depends on `req_valid`.
- `req_low` = 0 followed by another high phase merges into one longer high run. This is intended: it models the detectors' "not a one-cycle pulse" case.
- `done` is asserted during the last output cycle of each descriptor, concurrent with that cycle's `pulse` value.
- Reset values: `pulse` = 0, `busy` = 0, `done` = 0, state IDLE, `cnt` = 0. `req_ready` = 1 after reset deassertion.
- Reset mid-descriptor aborts immediately: `pulse` drops asynchronously, and the descriptor is discarded without `done`.

## Timing
- Latency: a handshake at edge k gives the first output level in cycle k+1, i.e. visible after edge k.
- A descriptor (h, l) occupies exactly h + l cycles on `pulse`. Descriptors back to back occupy the sum of those lengths, with no gaps.
- `busy` rises in the same cycle as the first output cycle. It falls after the last cycle, unless the next descriptor was accepted.
- `req_*` inputs are sampled only on the handshake edge. They may change freely otherwise.

## Configuration
- `PULSE_GEN_REPEAT_EN` defined:
  - Adds input `req_repeat` (LEN_W) and a repeat counter.
  - The captured (h, l) pair is played `req_repeat` + 1 times.
  - `done` and `req_ready` apply only to the final repetition.
  - An (h, l) pair of (0, 0) ignores the repeat count.
- `PULSE_GEN_REPEAT_EN` undefined: the port and counter are absent, and every descriptor plays exactly once.

## Structure
- Package `pulse_gen_pkg`:
  - Enum `pulse_gen_state_t` {IDLE, HIGH, LOW}.
  - Localparam `PULSE_GEN_LEN_W_DEFAULT` = 8.
- Sub-module `pulse_gen_down_counter`: a LEN_W-bit loadable down-counter with inputs load/value/dec and outputs count/zero. It is instantiated once for the phase count, and once more for repeats when `PULSE_GEN_REPEAT_EN` is defined.

## Test plan
- Reset: hold `rst` = 0 for 2 cycles → `pulse` = 0, `busy` = 0, `done` = 0, `req_ready` = 1. Assert `rst` = 0 during a HIGH phase of (5, 5) → `pulse` = 0 immediately and no `done`.
- Single (1, 3): handshake at edge 0 → `pulse` = 1,0,0,0 over cycles 1–4, `done` in cycle 4, then IDLE.
- Back-to-back (1,2), (3,1), (1,0), (2,1), each offered with `req_valid` held high. Output must be 1,0,0,1,1,1,0,1,1,1,0 with no gaps. The (1,0),(2,1) run merges into a 3-cycle high.
- Detector loopback: drive `a` of both detectors from `pulse` using descriptors for 16'b1000111001000100 (LSB first) → edge-detector and one-cycle-pulse-detector outputs match 16'b1000001001000100 and 16'b0000000010001000.
- Corner cases:
  - (0, 4) → four low cycles, `busy` = 1 throughout, `done` in cycle 4.
  - (0, 0) → no output activity, `done` 1 cycle after the handshake.
  - (255, 0) → exactly 255 high cycles.
- With `PULSE_GEN_REPEAT_EN`: (2, 1, repeat = 2) → 1,1,0,1,1,0,1,1,0, with `done` only in cycle 9.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// Shared types and defaults for the pulse train generator.
// Build with PULSE_GEN_REPEAT_EN defined to enable the per-descriptor repeat count.
package pulse_gen_pkg;

    localparam int PULSE_GEN_LEN_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } pulse_gen_state_t;

endpackage

// File: rtl/pulse_gen_down_counter.sv
// Loadable down-counter that saturates at zero; shared by the phase and repeat counts.
module pulse_gen_down_counter #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LEN_W-1:0] value,
    input  logic             dec,
    output logic [LEN_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pulse_train_generator.sv
// Plays (high, low) descriptors onto a registered pulse output with zero-bubble chaining.
// Optional feature macro: PULSE_GEN_REPEAT_EN adds req_repeat and a repeat counter.
module pulse_train_generator
    import pulse_gen_pkg::*;
#(
    parameter int LEN_W = PULSE_GEN_LEN_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [LEN_W-1:0] req_high,
    input  logic [LEN_W-1:0] req_low,
`ifdef PULSE_GEN_REPEAT_EN
    input  logic [LEN_W-1:0] req_repeat,
`endif
    output logic             pulse,
    output logic             busy,
    output logic             done
);

    pulse_gen_state_t state, state_nx;

    logic [LEN_W-1:0] cnt, cnt_val, cnt_next;
    logic [LEN_W-1:0] low_r, low_nx;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic             phase_end, pair_end, accept, noop;
    logic             rep_zero, rep_last_nx, done_nx;

    pulse_gen_down_counter #(.LEN_W(LEN_W)) u_phase_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .value (cnt_val),
        .dec   (cnt_dec),
        .count (cnt),
        .zero  (cnt_zero)
    );

`ifdef PULSE_GEN_REPEAT_EN
    logic [LEN_W-1:0] high_r, high_nx;
    logic [LEN_W-1:0] rep_val, rep_count, rep_next;
    logic             rep_load, rep_dec;

    pulse_gen_down_counter #(.LEN_W(LEN_W)) u_repeat_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (rep_load),
        .value (rep_val),
        .dec   (rep_dec),
        .count (rep_count),
        .zero  (rep_zero)
    );
`else
    assign rep_zero = 1'b1;
`endif

    // Next-state and counter control; req_ready depends only on registered state.
    always_comb begin
        state_nx = state;
        low_nx   = low_r;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        noop     = 1'b0;
`ifdef PULSE_GEN_REPEAT_EN
        high_nx  = high_r;
        rep_load = 1'b0;
        rep_val  = '0;
        rep_dec  = 1'b0;
`endif
        phase_end = (state != IDLE) && cnt_zero;
        pair_end  = phase_end && ((state == LOW) || (low_r == '0));
        req_ready = (state == IDLE) || (pair_end && rep_zero);
        accept    = req_valid && req_ready;

        if (accept) begin
            low_nx = req_low;
`ifdef PULSE_GEN_REPEAT_EN
            high_nx  = req_high;
            rep_load = 1'b1;
            rep_val  = ((req_high == '0) && (req_low == '0)) ? '0 : req_repeat;
`endif
            if (req_high != '0) begin
                state_nx = HIGH;
                cnt_load = 1'b1;
                cnt_val  = req_high - 1'b1;
            end else if (req_low != '0) begin
                state_nx = LOW;
                cnt_load = 1'b1;
                cnt_val  = req_low - 1'b1;
            end else begin
                state_nx = IDLE;
                noop     = 1'b1;
            end
        end else if (pair_end) begin
`ifdef PULSE_GEN_REPEAT_EN
            if (!rep_zero) begin
                rep_dec  = 1'b1;
                cnt_load = 1'b1;
                if (high_r != '0) begin
                    state_nx = HIGH;
                    cnt_val  = high_r - 1'b1;
                end else begin
                    state_nx = LOW;
                    cnt_val  = low_r - 1'b1;
                end
            end else begin
                state_nx = IDLE;
            end
`else
            state_nx = IDLE;
`endif
        end else if (phase_end) begin
            state_nx = LOW;
            cnt_load = 1'b1;
            cnt_val  = low_r - 1'b1;
        end else if (state != IDLE) begin
            cnt_dec = 1'b1;
        end

        cnt_next = cnt_load ? cnt_val : (cnt_dec ? cnt - 1'b1 : cnt);
`ifdef PULSE_GEN_REPEAT_EN
        rep_next    = rep_load ? rep_val : (rep_dec ? rep_count - 1'b1 : rep_count);
        rep_last_nx = (rep_next == '0);
`else
        rep_last_nx = 1'b1;
`endif
        // done is registered, so predict whether the next cycle is the descriptor's last.
        done_nx = noop || ((state_nx != IDLE) && (cnt_next == '0) &&
                           ((state_nx == LOW) || (low_nx == '0)) && rep_last_nx);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            low_r  <= '0;
`ifdef PULSE_GEN_REPEAT_EN
            high_r <= '0;
`endif
            pulse  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            low_r  <= low_nx;
`ifdef PULSE_GEN_REPEAT_EN
            high_r <= high_nx;
`endif
            pulse  <= (state_nx == HIGH);
            busy   <= (state_nx != IDLE);
            done   <= done_nx;
        end
    end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Self-checking bench for pulse_train_generator: per-cycle model comparison plus literal pattern checks.
// Define PULSE_GEN_REPEAT_EN for both RTL and bench to exercise the repeat feature.
module tb_pulse_train_generator;

    localparam int LEN_W = 8;

    typedef struct packed {
        logic p;
        logic b;
        logic d;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req_valid = 1'b0;
    logic [LEN_W-1:0] req_high = '0;
    logic [LEN_W-1:0] req_low = '0;
    logic             req_ready;
    logic             pulse, busy, done;
`ifdef PULSE_GEN_REPEAT_EN
    logic [LEN_W-1:0] req_repeat = '0;
`endif

    int   vectors = 0;
    int   fails = 0;
    exp_t q[$];
    logic cap_p[0:4095];
    logic cap_d[0:4095];
    int   cap_n = 0;

    pulse_train_generator #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_high  (req_high),
        .req_low   (req_low),
`ifdef PULSE_GEN_REPEAT_EN
        .req_repeat(req_repeat),
`endif
        .pulse     (pulse),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Model: each accepted descriptor expands into its per-cycle output sequence.
    initial begin
        exp_t e;
        logic rdy;
        int   h, l, r, tot;
        forever begin
            @(negedge clk);
            if (!rst) begin
                q.delete();
            end else begin
                e   = (q.size() > 0) ? q[0] : '{p: 1'b0, b: 1'b0, d: 1'b0};
                rdy = (q.size() <= 1);
                vectors++;
                if ({pulse, busy, done, req_ready} !== {e.p, e.b, e.d, rdy}) begin
                    fails++;
                    $display("[TB] FAIL cycle_check t=%0t: pulse/busy/done/ready got %b%b%b%b want %b%b%b%b",
                             $time, pulse, busy, done, req_ready, e.p, e.b, e.d, rdy);
                end
                if (q.size() > 0) begin
                    cap_p[cap_n] = pulse;
                    cap_d[cap_n] = done;
                    cap_n++;
                    void'(q.pop_front());
                end
                if (req_valid && rdy) begin
                    h = int'(req_high);
                    l = int'(req_low);
                    r = 0;
`ifdef PULSE_GEN_REPEAT_EN
                    r = int'(req_repeat);
`endif
                    if (h + l == 0) begin
                        q.push_back('{p: 1'b0, b: 1'b0, d: 1'b1});
                    end else begin
                        tot = (h + l) * (r + 1);
                        for (int i = 0; i < tot; i++)
                            q.push_back('{p: ((i % (h + l)) < h), b: 1'b1, d: (i == tot - 1)});
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Offer one descriptor and hold it until accepted; returns 1 ns after the handshake edge.
    task automatic applyStimulus(input int h, input int l);
        int n;
        req_valid = 1'b1;
        req_high  = LEN_W'(h);
        req_low   = LEN_W'(l);
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) checkOutput("handshake_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        req_valid = 1'b0;
        req_high  = 8'hA5;
        req_low   = 8'h5A;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) checkOutput("drain_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] getBits(input int base, input int len, input bit want_done);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < len; i++)
            v[i] = want_done ? cap_d[base + i] : cap_p[base + i];
        return v;
    endfunction

    initial begin
        int          base, ones, dones;
        logic [31:0] pat, edge_v, one_v;

        // Reset held for two cycles
        idleInputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_outputs", {28'd0, pulse, busy, done}, 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("ready_after_reset", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Single (1,3)
        base = cap_n;
        applyStimulus(1, 3);
        idleInputs();
        drain();
        checkOutput("single_len", cap_n - base, 32'd4);
        checkOutput("single_pulse", getBits(base, 4, 1'b0), 32'b0001);
        checkOutput("single_done", getBits(base, 4, 1'b1), 32'b1000);

        // Back-to-back with valid held high
        base = cap_n;
        applyStimulus(1, 2);
        applyStimulus(3, 1);
        applyStimulus(1, 0);
        applyStimulus(2, 1);
        idleInputs();
        drain();
        checkOutput("b2b_len", cap_n - base, 32'd11);
        checkOutput("b2b_pulse", getBits(base, 11, 1'b0), 32'b01110111001);
        checkOutput("b2b_done", getBits(base, 11, 1'b1), 32'b10011000100);

        // Detector loopback pattern, LSB first
        base = cap_n;
        applyStimulus(0, 2);
        applyStimulus(1, 3);
        applyStimulus(1, 2);
        applyStimulus(3, 3);
        applyStimulus(1, 0);
        idleInputs();
        drain();
        pat = getBits(base, 16, 1'b0);
        checkOutput("loop_pulse", pat, 32'b1000111001000100);
        checkOutput("loop_done", getBits(base, 16, 1'b1), 32'b1100000100100010);
        edge_v = '0;
        one_v  = '0;
        for (int i = 0; i < 16; i++) begin
            edge_v[i] = pat[i] & ~((i > 0) ? pat[i-1] : 1'b0);
            one_v[i]  = ~pat[i] & ((i > 0) ? pat[i-1] : 1'b0) & ~((i > 1) ? pat[i-2] : 1'b0);
        end
        checkOutput("loop_edge_det", edge_v, 32'b1000001001000100);
        checkOutput("loop_onecycle_det", one_v, 32'b0000000010001000);

        // (0,4): low-only descriptor
        base = cap_n;
        applyStimulus(0, 4);
        idleInputs();
        drain();
        checkOutput("low_only_pulse", getBits(base, 4, 1'b0), 32'b0000);
        checkOutput("low_only_done", getBits(base, 4, 1'b1), 32'b1000);

        // (0,0): no-op, done one cycle after handshake
        base = cap_n;
        applyStimulus(0, 0);
        idleInputs();
        drain();
        checkOutput("noop_len", cap_n - base, 32'd1);
        checkOutput("noop_done_pulse", {30'd0, cap_d[base], cap_p[base]}, 32'b10);

        // (255,0): longest high phase
        base = cap_n;
        applyStimulus(255, 0);
        idleInputs();
        drain();
        ones  = 0;
        dones = 0;
        for (int i = 0; i < cap_n - base; i++) begin
            ones  += int'(cap_p[base + i]);
            dones += int'(cap_d[base + i]);
        end
        checkOutput("max_high_len", cap_n - base, 32'd255);
        checkOutput("max_high_ones", ones, 32'd255);
        checkOutput("max_high_dones", dones, 32'd1);

`ifdef PULSE_GEN_REPEAT_EN
        base = cap_n;
        req_repeat = 8'd2;
        applyStimulus(2, 1);
        req_repeat = 8'd0;
        idleInputs();
        drain();
        checkOutput("repeat_pulse", getBits(base, 9, 1'b0), 32'b011011011);
        checkOutput("repeat_done", getBits(base, 9, 1'b1), 32'b100000000);
`endif

        // Reset during HIGH of (5,5) aborts at once
        applyStimulus(5, 5);
        idleInputs();
        @(posedge clk);
        #1;
        checkOutput("pre_abort_pulse", {31'd0, pulse}, 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("abort_outputs", {29'd0, pulse, busy, done}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("abort_no_done", {31'd0, done}, 32'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("post_abort_idle", {29'd0, pulse, busy, req_ready}, 32'b001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
